// File: rtl/imem_program_loader.sv
// imem_program_loader
//   Streams 32-bit instruction words from a valid/ready source into the
//   byte-wide write port of a little-endian instruction memory. Each word is
//   written as four byte writes at consecutive addresses, lowest byte first.
//   While a session is in progress, busy_o holds the core off.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous, active-high reset
//   start_i        one-cycle request to begin a load session
//   word_valid_i   word_data_i / word_last_i are valid
//   word_data_i    instruction word
//   word_last_i    final word of the program
//   word_ready_o   a word is accepted this cycle if word_valid_i is high
//   mem_we_o       byte write enable to the instruction memory
//   mem_addr_o     byte address of the write
//   mem_wdata_o    byte to write
//   busy_o         session in progress
//   done_o         session completed cleanly (level)
//   error_o        capacity overflow (level, held until the next start)
//   word_count_o   words fully written this session (saturating)
//   checksum_o     wrapping sum of written words (LOADER_CHECKSUM_EN only)
//
// Build option
//   LOADER_CHECKSUM_EN  adds checksum_o and its accumulator.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start, nothing loaded yet
// S_ACCEPT | word_ready high, waiting for the next word
// S_WRITE  | emitting byte byte_idx of the captured word
// S_DONE   | last word written, waiting for start
// S_ERR    | a word would not fit, waiting for start

module imem_program_loader #(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        word_valid_i,
  input  logic [31:0] word_data_i,
  input  logic        word_last_i,
  output logic        word_ready_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] word_count_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [63:0] MemBytes = 64'(MEM_BYTES);
  localparam logic [63:0] BaseAddr = 64'(BASE_ADDR);

  state_t      state_q, state_d;
  logic [63:0] ptr_q, ptr_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic [15:0] count_q, count_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic        word_fits;

  // A word fits only if all four of its bytes land below MEM_BYTES.
  assign word_fits = (ptr_q + 64'd4) <= MemBytes;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      count_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      last_q     <= last_d;
      count_q    <= count_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    last_d     = last_q;
    count_d    = count_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_ACCEPT;
          ptr_d   = BaseAddr;
          count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_ACCEPT: begin
        if (word_valid_i) begin
          if (word_fits) begin
            word_d     = word_data_i;
            last_d     = word_last_i;
            byte_idx_d = 2'd0;
            state_d    = S_WRITE;
          end else begin
            // The word is consumed by the handshake but never written.
            state_d = S_ERR;
          end
        end
      end
      S_WRITE: begin
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          ptr_d   = ptr_q + 64'd4;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q + word_q;
`endif
          state_d = last_q ? S_DONE : S_ACCEPT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign word_ready_o = (state_q == S_ACCEPT);
  assign busy_o       = (state_q == S_ACCEPT) || (state_q == S_WRITE);
  assign mem_we_o     = (state_q == S_WRITE);
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERR);
  assign word_count_o = count_q;

  // Address and data are forced to zero outside WRITE so the memory port
  // sees a quiet bus whenever mem_we_o is low.
  assign mem_addr_o   = mem_we_o ? (ptr_q + {62'd0, byte_idx_q}) : '0;
  assign mem_wdata_o  = mem_we_o ? word_q[{byte_idx_q, 3'b000} +: 8] : '0;

`ifdef LOADER_CHECKSUM_EN
  assign checksum_o   = csum_q;
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader. A 128-byte instance carries most of the
// scenarios; an 8-byte instance exercises capacity overflow. Expected byte
// writes come from a behavioural model: word i of a program lands at
// BASE + 4*i + k with byte k = bits 8k+7:8k, provided the whole word fits.
module tb_imem_program_loader;

  localparam int BASE = 0;
  localparam int MEM  = 128;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- 128-byte instance ----------------
  logic        reset = 1'b1, start = 1'b0, wv = 1'b0, wl = 1'b0;
  logic [31:0] wd = '0;
  logic        ready, mem_we, busy, done, error;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] wcount;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  imem_program_loader #(.MEM_BYTES(MEM), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .word_valid_i(wv),
    .word_data_i(wd), .word_last_i(wl), .word_ready_o(ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .busy_o(busy), .done_o(done), .error_o(error), .word_count_o(wcount)
`ifdef LOADER_CHECKSUM_EN
    , .checksum_o(csum)
`endif
  );

  // ---------------- 8-byte instance ----------------
  logic        s_reset = 1'b1, s_start = 1'b0, s_wv = 1'b0, s_wl = 1'b0;
  logic [31:0] s_wd = '0;
  logic        s_ready, s_we, s_busy, s_done, s_error;
  logic [63:0] s_addr;
  logic [7:0]  s_wdata;
  logic [15:0] s_wcount;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] s_csum;
`endif

  imem_program_loader #(.MEM_BYTES(8), .BASE_ADDR(0)) dut_small (
    .clk_i(clk), .reset_i(s_reset), .start_i(s_start), .word_valid_i(s_wv),
    .word_data_i(s_wd), .word_last_i(s_wl), .word_ready_o(s_ready),
    .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_wdata_o(s_wdata),
    .busy_o(s_busy), .done_o(s_done), .error_o(s_error), .word_count_o(s_wcount)
`ifdef LOADER_CHECKSUM_EN
    , .checksum_o(s_csum)
`endif
  );

  // ---------------- write monitors / instruction memory ----------------
  logic [63:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          wc_q[$];
  logic [63:0] s_wa_q[$];
  logic [7:0]  imem [0:MEM-1];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
      if (mem_addr < 64'(MEM)) imem[mem_addr[6:0]] = mem_wdata;
    end
    if (s_we === 1'b1) s_wa_q.push_back(s_addr);
  end

  // ---------------- reference model ----------------
  logic [31:0] prog[$];
  logic [63:0] exp_a[$];
  logic [7:0]  exp_d[$];
  logic [31:0] exp_sum;
  int          exp_words;
  int          hs, end_cyc;

  function automatic void build_expected(input int mem_bytes);
    exp_a.delete();
    exp_d.delete();
    exp_sum   = 32'd0;
    exp_words = 0;
    for (int i = 0; i < prog.size(); i++) begin
      if (BASE + 4 * (i + 1) > mem_bytes) break;
      for (int k = 0; k < 4; k++) begin
        exp_a.push_back(64'(BASE + 4 * i + k));
        exp_d.push_back(8'((prog[i] >> (8 * k)) & 32'hFF));
      end
      exp_sum   = exp_sum + prog[i];
      exp_words = exp_words + 1;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; wv = 1'b0; wl = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, output int hcyc);
    wv = 1'b1; wd = d; wl = l; hcyc = -1;
    for (int i = 0; i < 100; i++) begin
      if (ready === 1'b1) begin
        tick();
        hcyc = cyc;
        break;
      end
      tick();
    end
    wv = 1'b0; wd = $urandom; wl = 1'b0;
    if (hcyc < 0) begin
      checks++; errors++;
      $display("FAIL handshake: word_ready never rose, word %h", d);
    end
  endtask

  task automatic load_program(input int max_gap, input int mem_bytes);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    pulse_start();
    for (int i = 0; i < prog.size(); i++) begin
      send_word(prog[i], (i == prog.size() - 1), hs);
      if (BASE + 4 * (i + 1) > mem_bytes) break;
      if (i != prog.size() - 1) repeat ($urandom_range(max_gap, 0)) tick();
    end
  endtask

  task automatic wait_end();
    end_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1 || error === 1'b1) begin
        end_cyc = cyc;
        break;
      end
      tick();
    end
    if (end_cyc < 0) begin
      checks++; errors++;
      $display("FAIL session_end: neither done nor error within 60 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({ready, mem_we, busy, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {ready, mem_we, busy, done, error});
    end
    checks++;
    if (mem_addr !== 64'd0 || mem_wdata !== 8'd0 || wcount !== 16'd0) begin
      errors++;
      $display("FAIL reset_bus got addr=%0d data=%h cnt=%0d want 0/0/0", mem_addr, mem_wdata, wcount);
    end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (csum !== 32'd0) begin
      errors++;
      $display("FAIL reset_checksum got %h want 0", csum);
    end
`endif
  endtask

  task automatic test_single_word();
    logic [63:0] ea [4];
    logic [7:0]  ed [4];
    ea = '{64'd0, 64'd1, 64'd2, 64'd3};
    ed = '{8'h93, 8'h09, 8'h50, 8'h00};
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    pulse_start();
    checks++;
    if (ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency got ready=%b busy=%b want 1/1", ready, busy);
    end
    send_word(32'h00500993, 1'b1, hs);
    wait_end();
    checks++;
    if (end_cyc != hs + 4) begin
      errors++;
      $display("FAIL done_latency got %0d want %0d cycles after accept edge", end_cyc - hs, 4);
    end
    checks++;
    if (wa_q.size() != 4) begin
      errors++;
      $display("FAIL single_write_count got %0d want 4", wa_q.size());
    end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i] || wc_q[i] != wc_q[0] + i) begin
        errors++;
        $display("FAIL single_byte%0d got addr=%0d data=%h cyc+%0d want addr=%0d data=%h cyc+%0d",
                 i, wa_q[i], wd_q[i], wc_q[i] - wc_q[0], ea[i], ed[i], i);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || wcount !== 16'd1) begin
      errors++;
      $display("FAIL single_status got done=%b busy=%b err=%b cnt=%0d want 1/0/0/1", done, busy, error, wcount);
    end
  endtask

  task automatic test_bubble_sort();
    logic [31:0] img [28];
    logic [31:0] rb;
    img = '{32'h00500993, 32'h00000913, 32'h00000a13, 32'h01000a93,
            32'h00000b13, 32'h41298bb3, 32'hfffb8b93, 32'h000b0c13,
            32'h002c1c93, 32'h015c8cb3, 32'h000cad03, 32'h004cad83,
            32'h01ada663, 32'h01bca023, 32'h01acb223, 32'h001c0c13,
            32'hfc000ce3, 32'h00190913, 32'h01390463, 32'hfe0006e3,
            32'h00000013, 32'h00000013, 32'h00100073, 32'h00000013,
            32'h00000013, 32'h00000013, 32'h00000013, 32'h0000006f};
    prog.delete();
    for (int i = 0; i < 28; i++) prog.push_back(img[i]);
    load_program(2, MEM);
    wait_end();
    build_expected(MEM);
    checks++;
    if (wa_q.size() != exp_a.size()) begin
      errors++;
      $display("FAIL bubble_write_count got %0d want %0d", wa_q.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL bubble_write%0d got %0d:%h want %0d:%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if ({imem[67], imem[66], imem[65], imem[64]} !== 32'hfc000ce3) begin
      errors++;
      $display("FAIL bubble_word17 got %h want fc000ce3", {imem[67], imem[66], imem[65], imem[64]});
    end
    for (int i = 0; i < 28; i++) begin
      rb = {imem[4*i+3], imem[4*i+2], imem[4*i+1], imem[4*i]};
      checks++;
      if (rb !== img[i]) begin
        errors++;
        $display("FAIL bubble_readback%0d got %h want %h", i, rb, img[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || wcount !== 16'd28 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bubble_status got done=%b cnt=%0d busy=%b want 1/28/0", done, wcount, busy);
    end
  endtask

  task automatic test_gap_and_busy_start();
    logic [31:0] w0, w1;
    int          nw;
    w0 = $urandom; w1 = $urandom;
    prog.delete(); prog.push_back(w0); prog.push_back(w1);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    pulse_start();
    send_word(w0, 1'b0, hs);
    repeat (4) tick();
    nw = wa_q.size();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ready !== 1'b1 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL gap_cycle%0d got ready=%b we=%b want 1/0", i, ready, mem_we);
      end
      if (i == 1) start = 1'b1;
      tick();
      start = 1'b0;
    end
    checks++;
    if (wa_q.size() != nw) begin
      errors++;
      $display("FAIL gap_writes got %0d want %0d", wa_q.size(), nw);
    end
    send_word(w1, 1'b1, hs);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end();
    build_expected(MEM);
    checks++;
    if (wa_q.size() != exp_a.size()) begin
      errors++;
      $display("FAIL gap_write_count got %0d want %0d", wa_q.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL gap_write%0d got %0d:%h want %0d:%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || wcount !== 16'd2) begin
      errors++;
      $display("FAIL gap_status got done=%b cnt=%0d want 1/2", done, wcount);
    end
  endtask

  task automatic test_reset_mid_session();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    pulse_start();
    send_word(32'h11223344, 1'b0, hs);
    repeat (4) tick();
    send_word(32'h55667788, 1'b0, hs);
    tick(); tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 64'd6 || mem_wdata !== 8'h66) begin
      errors++;
      $display("FAIL midreset_pre got we=%b addr=%0d data=%h want 1/6/66", mem_we, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if ({ready, mem_we, busy, done, error} !== 5'b0 || mem_addr !== 64'd0 || mem_wdata !== 8'd0 || wcount !== 16'd0) begin
      errors++;
      $display("FAIL midreset_outputs got flags=%b addr=%0d data=%h cnt=%0d want 0",
               {ready, mem_we, busy, done, error}, mem_addr, mem_wdata, wcount);
    end
    checks++;
    if (wa_q.size() != 7) begin
      errors++;
      $display("FAIL midreset_partial got %0d writes want 7", wa_q.size());
    end
    tick();
    checks++;
    if (ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle got ready=%b we=%b want 0/0", ready, mem_we);
    end
    prog.delete(); prog.push_back(32'hCAFEF00D);
    load_program(0, MEM);
    wait_end();
    build_expected(MEM);
    checks++;
    if (wa_q.size() != 4 || wa_q[0] !== 64'(BASE) || wd_q[0] !== exp_d[0] || wa_q[3] !== exp_a[3]) begin
      errors++;
      $display("FAIL midreset_reload got n=%0d first_addr=%0d want 4 writes from %0d",
               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 64'hFFFF, BASE);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 5; s++) begin
      int n;
      n = (s == 4) ? 34 : $urandom_range(12, 1);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      load_program(3, MEM);
      wait_end();
      build_expected(MEM);
      checks++;
      if (wa_q.size() != exp_a.size()) begin
        errors++;
        $display("FAIL rand%0d_write_count got %0d want %0d", s, wa_q.size(), exp_a.size());
      end
      for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
        checks++;
        if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL rand%0d_write%0d got %0d:%h want %0d:%h", s, i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]);
        end
      end
      checks++;
      if (wcount !== 16'(exp_words) || done !== (exp_words == n) || error !== (exp_words != n)) begin
        errors++;
        $display("FAIL rand%0d_status got cnt=%0d done=%b err=%b want cnt=%0d done=%b err=%b",
                 s, wcount, done, error, exp_words, exp_words == n, exp_words != n);
      end
`ifdef LOADER_CHECKSUM_EN
      checks++;
      if (csum !== exp_sum) begin
        errors++;
        $display("FAIL rand%0d_checksum got %h want %h", s, csum, exp_sum);
      end
`endif
    end
  endtask

  task automatic s_send(input logic [31:0] d, input logic l);
    int got;
    got = 0;
    s_wv = 1'b1; s_wd = d; s_wl = l;
    for (int i = 0; i < 100; i++) begin
      if (s_ready === 1'b1) begin
        tick();
        got = 1;
        break;
      end
      tick();
    end
    s_wv = 1'b0; s_wl = 1'b0;
    if (got == 0) begin
      checks++; errors++;
      $display("FAIL small_handshake: word_ready never rose, word %h", d);
    end
  endtask

  task automatic test_overflow();
    s_reset = 1'b0;
    s_wa_q.delete();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_send($urandom, 1'b0);
    s_send($urandom, 1'b0);
    s_send($urandom, 1'b1);
    checks++;
    if (s_error !== 1'b1 || s_done !== 1'b0 || s_wcount !== 16'd2 || s_busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_status got err=%b done=%b cnt=%0d busy=%b ready=%b want 1/0/2/0/0",
               s_error, s_done, s_wcount, s_busy, s_ready);
    end
    repeat (3) tick();
    checks++;
    if (s_wa_q.size() != 8 || s_error !== 1'b1) begin
      errors++;
      $display("FAIL overflow_writes got n=%0d err=%b want 8/1", s_wa_q.size(), s_error);
    end
    for (int i = 0; i < 8 && i < s_wa_q.size(); i++) begin
      checks++;
      if (s_wa_q[i] !== 64'(i)) begin
        errors++;
        $display("FAIL overflow_addr%0d got %0d want %0d", i, s_wa_q[i], i);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    pulse_start();
    send_word(32'h00000001, 1'b0, hs);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (csum !== 32'h1 || ready !== 1'b1 || wcount !== 16'd1) begin
      errors++;
      $display("FAIL csum_first got csum=%h ready=%b cnt=%0d want 1/1/1", csum, ready, wcount);
    end
    send_word(32'hFFFFFFFF, 1'b1, hs);
    wait_end();
    repeat (3) tick();
    checks++;
    if (csum !== 32'h0 || wcount !== 16'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL csum_wrap got csum=%h cnt=%0d done=%b want 0/2/1", csum, wcount, done);
    end
    checks++;
    if (wa_q.size() != 8 || wa_q[4] !== 64'd4 || wd_q[7] !== 8'hFF) begin
      errors++;
      $display("FAIL csum_writes got n=%0d want 8 writes with second word at 4..7", wa_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_bubble_sort();
    test_gap_and_busy_start();
    test_reset_mid_session();
    test_random();
    test_overflow();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
